// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random engine: controller state
// encoding, shift-mode encoding and the default 8-bit tap constants.
package lfsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_AUTO  = 3'd2,
        ST_BURST = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    typedef enum logic {
        MODE_FIB = 1'b0,
        MODE_GAL = 1'b1
    } mode_e;

    // Kept 32 bits wide so any legal WIDTH can take a truncated copy.
    localparam logic [31:0] DEF_TAPS  = 32'h0000_00B8;
    localparam logic [31:0] DEF_GTAPS = 32'h0000_001D;

endpackage

// File: rtl/lfsr_prn_engine_tick_gen.sv
// tick_gen: free-running period divider for the auto-run mode.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   en_i   - count enable
//   clr_i  - synchronous clear to zero (wins over en_i)
//   tick_o - one-cycle pulse on the COUNT-th enabled cycle after a clear
module tick_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned COUNT = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lfsr_prn_engine.sv
// lfsr_prn_engine: seeded LFSR pseudo-random generator with manual step,
// periodic auto-run and fixed-length burst advance, Fibonacci or Galois form.
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   reset        - asynchronous active-low reset
//   seed         - seed value, taken on seed_load
//   seed_load    - pulse: load seed (and galois mode); highest priority
//   step         - pulse: one manual advance (READY only)
//   auto_en      - level: periodic advance every COUNT cycles
//   burst_start  - pulse: start burst of burst_len advances (READY only)
//   burst_len    - burst advance count, taken on burst_start
//   galois       - shift form, taken on seed_load (0 Fibonacci, 1 Galois)
//   prn          - current value (registered)
//   prn_valid    - pulse in the cycle prn takes a new value
//   busy         - high while bursting
//   error        - high while in the error state
//   period_wrap  - pulse with prn_valid when an advance returns to the seed
//
// state | meaning
// IDLE  | after reset, waiting for a nonzero seed
// READY | seeded, waiting for step / burst / auto
// AUTO  | advancing once every COUNT cycles while auto_en is high
// BURST | advancing every cycle until burst_len advances are done
// ERR   | zero seed or LFSR collapsed to zero; only a nonzero seed exits
module lfsr_prn_engine
    import lfsr_pkg::*;
#(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     TAPS    = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0]     GTAPS   = WIDTH'(DEF_GTAPS),
    parameter int unsigned          COUNT   = 500_000,
    parameter int unsigned          BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   seed,
    input  logic               seed_load,
    input  logic               step,
    input  logic               auto_en,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               galois,
    output logic [WIDTH-1:0]   prn,
    output logic               prn_valid,
    output logic               busy,
    output logic               error,
    output logic               period_wrap
);

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [WIDTH-1:0]     prn_q, prn_d;
    logic [WIDTH-1:0]     seed_q, seed_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                 prn_valid_q, prn_valid_d;
    logic                 wrap_q, wrap_d;
    logic [WIDTH-1:0]     fib_next, gal_next, adv_val;
    logic                 adv;
    logic                 tick_en, tick;

    assign fib_next = {prn_q[WIDTH-2:0], ^(prn_q & TAPS)};
    assign gal_next = {prn_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{prn_q[WIDTH-1]}} & GTAPS);
    assign adv_val  = (mode_q == MODE_GAL) ? gal_next : fib_next;

    // The divider only runs while auto-run will actually stay in AUTO, so
    // leaving AUTO (auto_en low or a reload) clears it on the same edge.
    assign tick_en = (state_q == ST_AUTO) && auto_en && !seed_load;

    tick_gen #(.COUNT(COUNT)) u_tick_gen (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (tick_en),
        .clr_i  (!tick_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        prn_d       = prn_q;
        seed_d      = seed_q;
        burst_cnt_d = burst_cnt_q;
        prn_valid_d = 1'b0;
        wrap_d      = 1'b0;
        adv         = 1'b0;

        if (seed_load) begin
            seed_d      = seed;
            mode_d      = mode_e'(galois);
            burst_cnt_d = '0;
            if (seed == '0) begin
                prn_d   = '0;
                state_d = ST_ERR;
            end else begin
                prn_d       = seed;
                prn_valid_d = 1'b1;
                state_d     = ST_READY;
            end
        end else begin
            unique case (state_q)
                ST_READY: begin
                    if (step) begin
                        adv = 1'b1;
                    end else if (burst_start && (burst_len != '0)) begin
                        state_d     = ST_BURST;
                        burst_cnt_d = burst_len;
                    end else if (auto_en) begin
                        state_d = ST_AUTO;
                    end
                end
                ST_AUTO: begin
                    if (!auto_en) begin
                        state_d = ST_READY;
                    end else if (tick) begin
                        adv = 1'b1;
                    end
                end
                ST_BURST: begin
                    adv         = 1'b1;
                    burst_cnt_d = burst_cnt_q - BURST_W'(1);
                    if (burst_cnt_q == BURST_W'(1)) begin
                        state_d = ST_READY;
                    end
                end
                default: begin
                end
            endcase

            if (adv) begin
                if (adv_val == '0) begin
                    prn_d       = '0;
                    state_d     = ST_ERR;
                    burst_cnt_d = '0;
                end else begin
                    prn_d       = adv_val;
                    prn_valid_d = 1'b1;
                    wrap_d      = (adv_val == seed_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_FIB;
            prn_q       <= '0;
            seed_q      <= '0;
            burst_cnt_q <= '0;
            prn_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            prn_q       <= prn_d;
            seed_q      <= seed_d;
            burst_cnt_q <= burst_cnt_d;
            prn_valid_q <= prn_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign prn         = prn_q;
    assign prn_valid   = prn_valid_q;
    assign period_wrap = wrap_q;
    assign busy        = (state_q == ST_BURST);
    assign error       = (state_q == ST_ERR);

endmodule

// File: tb/tb_lfsr_prn_engine.sv
module tb_lfsr_prn_engine;

    localparam int COUNT_TB = 4;
    localparam int FIB_TAPS = 'hB8;
    localparam int GAL_POLY = 'h1D;

    // model modes
    localparam int M_IDLE  = 0;
    localparam int M_READY = 1;
    localparam int M_AUTO  = 2;
    localparam int M_BURST = 3;
    localparam int M_ERR   = 4;

    logic       clk;
    logic       reset;
    logic [7:0] seed;
    logic       seed_load;
    logic       step;
    logic       auto_en;
    logic       burst_start;
    logic [7:0] burst_len;
    logic       galois;
    logic [7:0] prn;
    logic       prn_valid;
    logic       busy;
    logic       error;
    logic       period_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    int m_prn, m_seed, m_mode, m_ticks, m_burst;
    bit m_gal;
    int exp_valid, exp_wrap;
    int valid_seen, wrap_seen, busy_seen, adv_count, wrap_at;

    lfsr_prn_engine #(
        .WIDTH   (8),
        .COUNT   (COUNT_TB),
        .BURST_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seed        (seed),
        .seed_load   (seed_load),
        .step        (step),
        .auto_en     (auto_en),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .galois      (galois),
        .prn         (prn),
        .prn_valid   (prn_valid),
        .busy        (busy),
        .error       (error),
        .period_wrap (period_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next LFSR value from the polynomial definitions, using plain arithmetic.
    function automatic int model_adv(input int v, input bit gal);
        int n;
        int ones;
        ones = 0;
        if (gal) begin
            n = (v * 2) % 256;
            if (v >= 128) n = n ^ GAL_POLY;
        end else begin
            for (int b = 0; b < 8; b++)
                if ((((v >> b) & 1) == 1) && (((FIB_TAPS >> b) & 1) == 1)) ones++;
            n = ((v * 2) % 256) + (ones % 2);
        end
        return n;
    endfunction

    task automatic model_reset();
        m_prn = 0; m_seed = 0; m_mode = M_IDLE; m_ticks = 0; m_burst = 0; m_gal = 0;
        exp_valid = 0; exp_wrap = 0;
    endtask

    task automatic model_advance();
        int n;
        n = model_adv(m_prn, m_gal);
        if (n == 0) begin
            m_prn = 0;
            m_mode = M_ERR;
        end else begin
            m_prn = n;
            exp_valid = 1;
            exp_wrap = (n == m_seed) ? 1 : 0;
        end
    endtask

    task automatic model_step();
        exp_valid = 0;
        exp_wrap  = 0;
        if (seed_load) begin
            m_seed = seed; m_gal = galois; m_burst = 0; m_ticks = 0;
            if (seed == 0) begin
                m_prn = 0; m_mode = M_ERR;
            end else begin
                m_prn = seed; exp_valid = 1; m_mode = M_READY;
            end
        end else begin
            case (m_mode)
                M_READY: begin
                    if (step) model_advance();
                    else if (burst_start && burst_len != 0) begin
                        m_mode = M_BURST; m_burst = burst_len;
                    end else if (auto_en) begin
                        m_mode = M_AUTO; m_ticks = 0;
                    end
                end
                M_AUTO: begin
                    if (!auto_en) m_mode = M_READY;
                    else begin
                        m_ticks++;
                        if (m_ticks == COUNT_TB) begin
                            m_ticks = 0;
                            model_advance();
                        end
                    end
                end
                M_BURST: begin
                    m_burst--;
                    model_advance();
                    if (m_mode != M_ERR && m_burst == 0) m_mode = M_READY;
                end
                default: ;
            endcase
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("prn", prn, m_prn);
        check_eq("prn_valid", prn_valid, exp_valid);
        check_eq("period_wrap", period_wrap, exp_wrap);
        check_eq("busy", busy, (m_mode == M_BURST) ? 1 : 0);
        check_eq("error", error, (m_mode == M_ERR) ? 1 : 0);
        if (prn_valid) begin valid_seen++; adv_count++; end
        if (period_wrap) begin wrap_seen++; wrap_at = adv_count; end
        if (busy) busy_seen++;
        seed_load = 1'b0; step = 1'b0; burst_start = 1'b0;
    endtask

    task automatic load(input int s, input bit g);
        seed = s[7:0]; galois = g; seed_load = 1'b1;
        clk_cycle();
    endtask

    initial begin
        int fib_exp[5];
        fib_exp = '{'h02, 'h04, 'h08, 'h11, 'h23};

        reset = 1'b0; seed = '0; seed_load = 0; step = 0; auto_en = 0;
        burst_start = 0; burst_len = '0; galois = 0;
        model_reset();
        #12;
        check_eq("rst_prn", prn, 0);
        check_eq("rst_valid", prn_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_wrap", period_wrap, 0);
        @(negedge clk);
        reset = 1'b1;

        // IDLE ignores everything but seed_load
        step = 1; clk_cycle();
        burst_len = 8'd4; burst_start = 1; clk_cycle();
        auto_en = 1; repeat (6) clk_cycle(); auto_en = 0;
        check_eq("idle_prn", prn, 0);

        // Fibonacci known sequence
        load('h01, 0);
        check_eq("fib_load", prn, 'h01);
        for (int i = 0; i < 5; i++) begin
            valid_seen = 0;
            step = 1; clk_cycle();
            check_eq("fib_seq", prn, fib_exp[i]);
            check_eq("fib_valid_pulses", valid_seen, 1);
            clk_cycle();
        end

        // Galois known sequence
        load('h80, 1);
        step = 1; clk_cycle();
        check_eq("gal_step1", prn, 'h1D);
        step = 1; clk_cycle();
        check_eq("gal_step2", prn, 'h3A);

        // Zero seed -> ERR, recovered only by nonzero seed
        load('h00, 0);
        check_eq("zero_error", error, 1);
        check_eq("zero_prn", prn, 0);
        step = 1; clk_cycle();
        check_eq("err_step_ignored", prn, 0);
        load('h01, 0);
        check_eq("err_exit_error", error, 0);
        check_eq("err_exit_prn", prn, 'h01);

        // Auto-run, COUNT=4: advances at the 4th, 8th, 12th cycle after entry
        valid_seen = 0;
        auto_en = 1;
        repeat (16) clk_cycle();
        check_eq("auto_advances", valid_seen, 3);
        auto_en = 0;
        valid_seen = 0;
        repeat (10) clk_cycle();
        check_eq("auto_off_advances", valid_seen, 0);

        // Burst of 3
        load('h01, 0);
        valid_seen = 0; busy_seen = 0;
        burst_len = 8'd3; burst_start = 1;
        repeat (6) clk_cycle();
        check_eq("burst_valids", valid_seen, 3);
        check_eq("burst_busy_cycles", busy_seen, 3);

        // seed_load aborts a burst
        burst_len = 8'd10; burst_start = 1;
        repeat (3) clk_cycle();
        load('h5A, 0);
        check_eq("abort_prn", prn, 'h5A);
        check_eq("abort_busy", busy, 0);
        valid_seen = 0;
        repeat (4) clk_cycle();
        check_eq("abort_no_more", valid_seen, 0);

        // Full Fibonacci period wraps exactly once, on advance 255
        load('h01, 0);
        adv_count = 0; wrap_seen = 0; wrap_at = -1;
        burst_len = 8'd255; burst_start = 1;
        repeat (258) clk_cycle();
        check_eq("period_wrap_count", wrap_seen, 1);
        check_eq("period_wrap_at", wrap_at, 255);
        check_eq("period_final_prn", prn, 'h01);

        // Reset in the middle of a burst discards it
        burst_len = 8'd20; burst_start = 1;
        repeat (4) clk_cycle();
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_prn", prn, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", prn_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step = 1; clk_cycle();
        check_eq("midrst_idle", prn, 0);

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                seed = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                galois = 1'($urandom_range(0, 1));
                seed_load = 1;
            end else if (r < 15) begin
                step = 1;
            end else if (r < 21) begin
                burst_len = 8'($urandom_range(0, 12));
                burst_start = 1;
            end
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            if (m_mode == M_IDLE && r >= 90) begin
                seed = 8'($urandom_range(1, 255));
                galois = 1'($urandom_range(0, 1));
                seed_load = 1;
            end
            clk_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
